regfile_write_queue: RTL and testbench

//  Write-back queue that sits directly upstream of the 32x32-bit register file's single write port.
//  - Two producers (p0 = ALU, p1 = load unit) each present {addr,data} with valid/ready.
//  - The queue buffers the requests and drains at most one per cycle onto address_w/enable_w/data_w.
//  - Optional bypass lookup: the read stage can see values not yet committed to the register file.

---
 rtl/regfile_write_queue.sv | 132 +++++++++++++
 tb/tb_regfile_write_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Write-back queue feeding the register file's single write port; two producers, one drain per cycle.
// Build with WQ_BYPASS_EN defined to enable the combinational bypass lookup ports.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_data,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_data,
  output logic          enable_w,
  output logic [AW-1:0] address_w,
  output logic [DW-1:0] data_w,
  input  logic [AW-1:0] look_addr_a,
  output logic          look_hit_a,
  output logic [DW-1:0] look_data_a,
  input  logic [AW-1:0] look_addr_b,
  output logic          look_hit_b,
  output logic [DW-1:0] look_data_b,
  output logic [CW-1:0] count
);

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [AW-1:0] mem_addr_d [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [DW-1:0] mem_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic [PW-1:0] p1_slot;
  logic          push0, push1, pop;

  // Credit comes only from registered occupancy; a pop in this cycle does not free a slot.
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    p0_ready = rst_n && (free != '0);
    p1_ready = rst_n && (p0_valid ? (free >= CW'(2)) : (free != '0));
    push0    = p0_valid && p0_ready;
    push1    = p1_valid && p1_ready;
    pop      = (count_q != '0);
    p1_slot  = wr_ptr_q + PW'(push0);
    wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (push0) begin
      mem_addr_d[wr_ptr_q] = p0_addr;
      mem_data_d[wr_ptr_q] = p0_data;
    end
    if (push1) begin
      mem_addr_d[p1_slot] = p1_addr;
      mem_data_d[p1_slot] = p1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  always_comb begin
    enable_w  = pop;
    address_w = pop ? mem_addr_q[rd_ptr_q] : '0;
    data_w    = pop ? mem_data_q[rd_ptr_q] : '0;
    count     = count_q;
  end

`ifdef WQ_BYPASS_EN
  logic [PW-1:0] look_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    look_hit_a  = 1'b0;
    look_data_a = '0;
    look_hit_b  = 1'b0;
    look_data_b = '0;
    look_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      look_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_addr_q[look_idx] == look_addr_a) begin
          look_hit_a  = 1'b1;
          look_data_a = mem_data_q[look_idx];
        end
        if (mem_addr_q[look_idx] == look_addr_b) begin
          look_hit_b  = 1'b1;
          look_data_b = mem_data_q[look_idx];
        end
      end
    end
  end
`else
  logic unused_look;

  assign unused_look = ^{look_addr_a, look_addr_b};

  always_comb begin
    look_hit_a  = 1'b0;
    look_data_a = '0;
    look_hit_b  = 1'b0;
    look_data_b = '0;
  end
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: directed scenarios plus random traffic against a queue-based reference.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          p0_valid, p1_valid;
  logic          p0_ready, p1_ready;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_data, p1_data;
  logic          enable_w;
  logic [AW-1:0] address_w;
  logic [DW-1:0] data_w;
  logic [AW-1:0] look_addr_a, look_addr_b;
  logic          look_hit_a, look_hit_b;
  logic [DW-1:0] look_data_a, look_data_b;
  logic [2:0]    count;

  regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .enable_w(enable_w), .address_w(address_w), .data_w(data_w),
    .look_addr_a(look_addr_a), .look_hit_a(look_hit_a), .look_data_a(look_data_a),
    .look_addr_b(look_addr_b), .look_hit_b(look_hit_b), .look_data_b(look_data_b),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  entry_t model_q[$];
  int     errors = 0;
  int     checks = 0;
  int     n_writes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_look(input logic [AW-1:0] addr, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (BYP) begin
      foreach (model_q[i]) begin
        if (model_q[i].a == addr) begin
          hit  = 1'b1;
          data = model_q[i].d;
        end
      end
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic tick(output bit acc0, output bit acc1);
    int       free;
    bit       r0, r1;
    logic     eh;
    logic [DW-1:0] ed;
    #1;
    free = DEPTH - model_q.size();
    r0 = (free >= 1);
    r1 = p0_valid ? (free >= 2) : (free >= 1);
    chk("p0_ready", p0_ready, r0);
    chk("p1_ready", p1_ready, r1);
    chk("count", count, model_q.size());
    chk("enable_w", enable_w, model_q.size() > 0);
    chk("address_w", address_w, (model_q.size() > 0) ? model_q[0].a : '0);
    chk("data_w", data_w, (model_q.size() > 0) ? model_q[0].d : '0);
    model_look(look_addr_a, eh, ed);
    chk("look_hit_a", look_hit_a, eh);
    chk("look_data_a", look_data_a, ed);
    model_look(look_addr_b, eh, ed);
    chk("look_hit_b", look_hit_b, eh);
    chk("look_data_b", look_data_b, ed);
    if (enable_w === 1'b1) n_writes++;
    acc0 = p0_valid && r0;
    acc1 = p1_valid && r1;
    @(posedge clk);
    if (model_q.size() > 0) void'(model_q.pop_front());
    if (acc0) model_q.push_back('{p0_addr, p0_data});
    if (acc1) model_q.push_back('{p1_addr, p1_data});
    @(negedge clk);
  endtask

  initial begin
    bit a0, a1;
    bit hold0, hold1;
    logic [31:0] h;
    rst_n = 1'b0;
    look_addr_a = '0;
    look_addr_b = '0;
    drive(0, '0, '0, 0, '0, '0);
    #1;
    chk("reset_enable_w", enable_w, 0);
    chk("reset_count", count, 0);
    chk("reset_ready", {p0_ready, p1_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: single push, one-cycle write
    drive(1, 5'd3, 32'h6, 0, '0, '0);
    tick(a0, a1);
    drive(0, '0, '0, 0, '0, '0);
    #1;
    chk("s1_en", enable_w, 1);
    chk("s1_addr", address_w, 3);
    chk("s1_data", data_w, 32'h6);
    tick(a0, a1);
    chk("s1_en_after", enable_w, 0);
    chk("s1_count_after", count, 0);
    tick(a0, a1);

    // Scenario 2: same-address dual push, bypass sees youngest
    drive(1, 5'd5, 32'hA, 1, 5'd5, 32'hB);
    tick(a0, a1);
    drive(0, '0, '0, 0, '0, '0);
    look_addr_a = 5'd5;
    #1;
    chk("s2_data0", data_w, 32'hA);
    chk("s2_hit_a", look_hit_a, BYP);
    chk("s2_look_a", look_data_a, BYP ? 32'hB : 32'h0);
    tick(a0, a1);
    chk("s2_data1", data_w, 32'hB);
    tick(a0, a1);
    look_addr_a = '0;
    tick(a0, a1);

    // Scenario 6: lookup miss
    look_addr_b = 5'd31;
    drive(1, 5'd7, 32'h77, 0, '0, '0);
    tick(a0, a1);
    drive(0, '0, '0, 0, '0, '0);
    #1;
    chk("s6_hit_b", look_hit_b, 0);
    chk("s6_data_b", look_data_b, 0);
    tick(a0, a1);
    tick(a0, a1);

    // Scenario 3: both producers held valid from empty
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i), 32'h100 + i, 1, 5'(i + 16), 32'h200 + i);
      #1;
      if (model_q.size() == DEPTH - 1) chk("s3_free1_ready", {p0_ready, p1_ready}, 2'b10);
      if (model_q.size() > 0) chk("s3_enable", enable_w, 1);
      tick(a0, a1);
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (5) tick(a0, a1);

    // Scenario 4: nine p0 pushes across pointer wrap
    n_writes = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'(i), 32'(2 * i), 0, '0, '0);
      tick(a0, a1);
      chk("s4_accepted", a0, 1);
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (3) tick(a0, a1);
    chk("s4_write_count", n_writes, 9);

    // Scenario 5: asynchronous reset with three entries queued
    drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    tick(a0, a1);
    drive(1, 5'd3, 32'h33, 1, 5'd4, 32'h44);
    tick(a0, a1);
    drive(0, '0, '0, 0, '0, '0);
    look_addr_a = 5'd3;
    #1;
    chk("s5_count3", count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_enable", enable_w, 0);
    chk("s5_rst_count", count, 0);
    chk("s5_rst_addr", address_w, 0);
    chk("s5_rst_ready", {p0_ready, p1_ready}, 0);
    chk("s5_rst_hit", look_hit_a, 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(a0, a1);

    // Random traffic with stalled producers holding their request
    hold0 = 0;
    hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        p0_valid = ($urandom_range(0, 3) != 0);
        p0_addr  = 5'($urandom_range(0, 7));
        p0_data  = $urandom;
      end
      if (!hold1) begin
        p1_valid = ($urandom_range(0, 2) != 0);
        h        = $urandom;
        p1_addr  = (h[0]) ? 5'($urandom_range(0, 7)) : 5'(h[12:8]);
        p1_data  = $urandom;
      end
      look_addr_a = 5'($urandom_range(0, 7));
      look_addr_b = 5'($urandom_range(0, 31));
      tick(a0, a1);
      hold0 = p0_valid && !a0;
      hold1 = p1_valid && !a1;
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (6) tick(a0, a1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
